// File: rtl/btisa_fetch_unit.sv
// Instruction fetch stage for the balanced-ternary CPU: binary PC, single
// outstanding instruction-memory request, small instruction FIFO towards decode.

package btisa_pkg;
   typedef logic [1:0] trit_t;
   localparam trit_t T_ZERO = 2'b00;
   localparam trit_t T_POS  = 2'b01;
   localparam trit_t T_NEG  = 2'b10;
   typedef trit_t [8:0] instr_t;
endpackage

module btisa_fetch_unit
   import btisa_pkg::*;
#(
   parameter int                 ADDR_W     = 8,
   parameter int                 FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          imem_req_valid,
   input  logic                          imem_req_ready,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic                          imem_rsp_valid,
   input  instr_t                        imem_rsp_data,
   output logic                          if_valid,
   input  logic                          if_ready,
   output instr_t                        if_instr,
   output logic [ADDR_W-1:0]             if_pc,
   input  logic                          redirect,
   input  logic [ADDR_W-1:0]             redirect_pc,
   input  logic                          halt,
   output logic                          halted,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              drop_q, drop_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   instr_t            instr_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem_q    [FIFO_DEPTH];

   logic outstanding;
   logic flush;
   logic accept;
   logic push;
   logic pop;

   // A response is still owed either in WAIT or after a halt that left one in flight.
   assign outstanding = (state_q == ST_WAIT) || ((state_q == ST_HALTED) && drop_q);
   assign flush       = halt || (redirect && (state_q != ST_HALTED));

   assign imem_req_valid = !rst && (state_q == ST_IDLE) && !redirect && !halt &&
                           (count_q < CNT_W'(FIFO_DEPTH));
   assign imem_addr      = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign push = !flush && (state_q == ST_WAIT) && imem_rsp_valid && !drop_q;
   assign pop  = !flush && if_valid && if_ready;

   assign if_valid   = (count_q != '0);
   assign if_instr   = if_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign halted     = (state_q == ST_HALTED);
   assign fifo_count = count_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      drop_d   = drop_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = outstanding && !imem_rsp_valid;
         if (halt) begin
            state_d = ST_HALTED;
         end else begin
            pc_d    = redirect_pc;
            state_d = drop_d ? ST_WAIT : ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  pc_d     = pc_q + ADDR_W'(1);
                  req_pc_d = pc_q;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  drop_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            ST_HALTED: begin
               if (imem_rsp_valid) begin
                  drop_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         drop_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is not reset; the head is masked while empty, so stale words never escape.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rsp_data;
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
      end
   end

`ifndef SYNTHESIS
   rsp_without_request: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> outstanding)
      else $error("imem response with no outstanding request");
`endif

endmodule

// File: tb/tb_btisa_fetch_unit.sv
// Bench for btisa_fetch_unit: cycle vector table, hand-written corner sequences,
// and a randomized run checked against a PC-stream reference model.

module tb_btisa_fetch_unit;
   import btisa_pkg::*;

   localparam int         ADDR_W   = 8;
   localparam int         DEPTH    = 2;
   localparam logic [7:0] RESET_PC = 8'h00;

   logic         clk = 1'b0;
   logic         rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic         if_valid, if_ready, redirect, halt, halted;
   logic [7:0]   imem_addr, if_pc, redirect_pc;
   instr_t       imem_rsp_data, if_instr;
   logic [1:0]   fifo_count;

   always #5 clk = ~clk;

   btisa_fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
      .fifo_count(fifo_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   // Memory image: each word holds its own address in balanced ternary.
   function automatic instr_t instr_of(input logic [7:0] a);
      instr_t r;
      int v;
      v = int'(a);
      for (int i = 0; i < 9; i++) begin
         case (v % 3)
            0:       begin r[i] = T_ZERO; v = v / 3;       end
            1:       begin r[i] = T_POS;  v = v / 3;       end
            default: begin r[i] = T_NEG;  v = (v + 1) / 3; end
         endcase
      end
      return r;
   endfunction

   // Memory responder: answers an accepted request mem_lat cycles later.
   int         mem_lat  = 1;
   bit         mem_pend = 0;
   int         mem_tmr  = 0;
   logic [7:0] mem_addr = '0;

   task automatic settle();
      imem_rsp_valid = mem_pend && (mem_tmr == 0);
      imem_rsp_data  = imem_rsp_valid ? instr_of(mem_addr) : '0;
      #1;
   endtask

   task automatic advance();
      bit         acc, rsp_now;
      logic [7:0] acc_addr;
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_addr;
      rsp_now  = imem_rsp_valid;
      @(posedge clk);
      if (rst) begin
         mem_pend = 0;
      end else begin
         if (rsp_now) mem_pend = 0;
         else if (mem_pend) mem_tmr--;
         if (acc) begin
            mem_pend = 1;
            mem_tmr  = mem_lat - 1;
            mem_addr = acc_addr;
         end
      end
      #1;
   endtask

   task automatic do_reset(input bit chk);
      rst = 1'b1; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
      if_ready = 1'b0; imem_req_ready = 1'b0;
      settle(); advance();
      settle(); advance();
      settle();
      if (chk) begin
         check("rst.req_valid", 32'(imem_req_valid), 0);
         check("rst.addr",      32'(imem_addr), 32'(RESET_PC));
         check("rst.if_valid",  32'(if_valid), 0);
         check("rst.if_instr",  32'(if_instr), 0);
         check("rst.if_pc",     32'(if_pc), 0);
         check("rst.halted",    32'(halted), 0);
         check("rst.count",     32'(fifo_count), 0);
      end
      rst = 1'b0;
   endtask

   task automatic expect_next_req(input logic [7:0] a, input string nm);
      bit found;
      found = 0;
      for (int k = 0; k < 30; k++) begin
         settle();
         if (imem_req_valid) begin found = 1; break; end
         advance();
      end
      if (!found) settle();
      check({nm, ".seen"}, 32'(found), 1);
      if (found) check({nm, ".addr"}, 32'(imem_addr), 32'(a));
   endtask

   task automatic expect_next_out(input logic [7:0] a, input string nm);
      bit found;
      found = 0;
      for (int k = 0; k < 30; k++) begin
         settle();
         if (if_valid) begin found = 1; break; end
         advance();
      end
      if (!found) settle();
      check({nm, ".seen"}, 32'(found), 1);
      if (found) begin
         check({nm, ".pc"},    32'(if_pc), 32'(a));
         check({nm, ".instr"}, 32'(if_instr), 32'(instr_of(a)));
      end
   endtask

   typedef struct packed {
      logic       rr;    // imem_req_ready
      logic       ir;    // if_ready
      logic       ev;    // expected imem_req_valid
      logic [7:0] ea;    // expected imem_addr
      logic       eiv;   // expected if_valid
      logic [7:0] epc;   // expected if_pc when valid
      logic [1:0] ecnt;  // expected fifo_count
   } vec_t;

   vec_t vt [15];

   initial begin
      int         quiet_bad, consumed;
      logic [7:0] exp_pc, prev_addr;
      bit         prev_stall, rr, ir, rd;

      // 1-cycle memory from reset: alternate-cycle fetch, request stall, FIFO fill, drain.
      vt[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 2'd0};
      vt[2]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 2'd1};
      vt[3]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 2'd0};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 2'd1};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 2'd1};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 2'd1};
      vt[7]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 2'd1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h01, 2'd1};
      vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h01, 2'd2};
      vt[10] = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h01, 2'd2};
      vt[11] = '{1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 8'h01, 2'd2};
      vt[12] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h02, 2'd1};
      vt[13] = '{1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h00, 2'd0};
      vt[14] = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h03, 2'd1};

      do_reset(1);
      mem_lat = 1;
      for (int i = 0; i < 15; i++) begin
         imem_req_ready = vt[i].rr;
         if_ready       = vt[i].ir;
         settle();
         check($sformatf("v%0d.req_valid", i), 32'(imem_req_valid), 32'(vt[i].ev));
         check($sformatf("v%0d.addr", i),      32'(imem_addr),      32'(vt[i].ea));
         check($sformatf("v%0d.if_valid", i),  32'(if_valid),       32'(vt[i].eiv));
         check($sformatf("v%0d.count", i),     32'(fifo_count),     32'(vt[i].ecnt));
         if (vt[i].eiv) begin
            check($sformatf("v%0d.if_pc", i),    32'(if_pc),    32'(vt[i].epc));
            check($sformatf("v%0d.if_instr", i), 32'(if_instr), 32'(instr_of(vt[i].epc)));
         end
         advance();
      end

      // Redirect while a 3-cycle response is in flight and the FIFO holds an entry.
      do_reset(0);
      mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
      settle(); advance();
      mem_lat = 3;
      settle(); advance();
      settle(); check("A.pre_count", 32'(fifo_count), 1); advance();
      redirect = 1'b1; redirect_pc = 8'h40;
      settle(); check("A.req_in_redirect", 32'(imem_req_valid), 0);
      advance(); redirect = 1'b0;
      settle();
      check("A.flush_valid", 32'(if_valid), 0);
      check("A.flush_count", 32'(fifo_count), 0);
      advance();
      if_ready = 1'b1;
      expect_next_req(8'h40, "A.req"); advance();
      expect_next_out(8'h40, "A.out");

      // Response arriving in the redirect cycle must not be delivered.
      do_reset(0);
      mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
      settle(); advance();
      redirect = 1'b1; redirect_pc = 8'h10;
      settle(); advance(); redirect = 1'b0;
      settle();
      check("B.dropped",   32'(if_valid), 0);
      check("B.req_valid", 32'(imem_req_valid), 1);
      check("B.req_addr",  32'(imem_addr), 32'h10);
      if_ready = 1'b1;
      advance();
      expect_next_out(8'h10, "B.out");

      // PC wrap at the top of the address space.
      do_reset(0);
      mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 8'hFF;
      settle(); check("D.req_in_redirect", 32'(imem_req_valid), 0);
      advance(); redirect = 1'b0;
      expect_next_req(8'hFF, "D.req_ff"); advance();
      expect_next_req(8'h00, "D.req_wrap"); advance();
      if_ready = 1'b1;
      expect_next_out(8'hFF, "D.out_ff"); advance();
      expect_next_out(8'h00, "D.out_wrap");

      // Halt together with redirect while a response is outstanding.
      do_reset(0);
      mem_lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
      settle(); advance();
      halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h33;
      settle(); check("C.req_in_halt", 32'(imem_req_valid), 0);
      advance(); halt = 1'b0; redirect = 1'b0;
      settle(); check("C.halted", 32'(halted), 1);
      quiet_bad = 0;
      for (int k = 0; k < 10; k++) begin
         redirect = (k % 3 == 0); redirect_pc = 8'h55;
         settle();
         if (!halted || imem_req_valid || if_valid) quiet_bad++;
         advance();
      end
      redirect = 1'b0;
      check("C.stays_halted", 32'(quiet_bad), 0);
      do_reset(0);
      imem_req_ready = 1'b1;
      settle(); check("C.unhalted", 32'(halted), 0);
      expect_next_req(RESET_PC, "C.restart");

      // Randomized run: delivered PCs must form a gap-free stream restarting at each redirect target.
      do_reset(0);
      exp_pc = RESET_PC; consumed = 0; prev_stall = 0; prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         rr = ($urandom % 4) != 0;
         ir = ($urandom % 3) != 0;
         rd = ($urandom % 25) == 0;
         if (rd) ir = 1'b0;
         mem_lat        = int'($urandom_range(1, 4));
         imem_req_ready = rr;
         if_ready       = ir;
         redirect       = rd;
         redirect_pc    = 8'($urandom);
         settle();
         if (prev_stall && !rd) begin
            check($sformatf("R%0d.req_held", c),  32'(imem_req_valid), 1);
            check($sformatf("R%0d.addr_held", c), 32'(imem_addr), 32'(prev_addr));
         end
         if (if_valid && if_ready) begin
            check($sformatf("R%0d.pc", c),    32'(if_pc), 32'(exp_pc));
            check($sformatf("R%0d.instr", c), 32'(if_instr), 32'(instr_of(exp_pc)));
            exp_pc = exp_pc + 8'd1;
            consumed++;
         end
         if (rd) exp_pc = redirect_pc;
         prev_stall = imem_req_valid && !rr;
         prev_addr  = imem_addr;
         advance();
      end
      redirect = 1'b0;
      check("R.progress", 32'(consumed > 300), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
